tick_src_select: RTL

- Parametrised N-channel tick-source selector; successor to the 4:1 clock-source mux that feeds the up/down counters.
- Channel inputs are single-cycle tick strobes from clock-enable dividers in the one system clock domain; they are not clocks.
- The board switch select is synchronised and debounced, then applied through a controlled switchover so downstream counters never see a glitch or a double tick.
- Output is a registered tick plus the active channel index.

---
 rtl/tick_src_select.sv | 74 +++++++
 1 files changed

// File: rtl/tick_src_select.sv
// tick_src_select: debounced, glitch-free selection of one of N_CH single-cycle tick strobes.
// Select changes pass a 2-flop sync and stability filter, then take effect through a 1-cycle SWITCH state.
module tick_src_select #(
    parameter int N_CH      = 4,
    parameter int SEL_W     = 2,
    parameter int DB_CYCLES = 16,
    parameter int RST_SEL   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_CH-1:0]  tick_i,
    input  logic [SEL_W-1:0] sw,
    input  logic             en,
    output logic             tick_o,
    output logic [SEL_W-1:0] sel_o,
    output logic             switching_o
);
    localparam int               CNT_W   = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0] DB_MAX  = CNT_W'(DB_CYCLES - 1);
    localparam logic [SEL_W-1:0] SEL_RST = SEL_W'(RST_SEL);
    localparam logic [SEL_W:0]   NCH_LIM = (SEL_W + 1)'(N_CH);

    typedef enum logic {RUN, SWITCH} state_t;

    state_t           r_state, w_next;
    logic [SEL_W-1:0] r_sw_meta, r_sw_s, r_cand, r_sel;
    logic [CNT_W-1:0] r_db_cnt;
    logic             r_tick;
    logic             w_stable, w_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sw_meta <= SEL_RST;
            r_sw_s    <= SEL_RST;
            r_cand    <= SEL_RST;
            r_db_cnt  <= '0;
        end else begin
            r_sw_meta <= sw;
            r_sw_s    <= r_sw_meta;
            if (r_sw_s != r_cand) begin
                r_cand   <= r_sw_s;
                r_db_cnt <= '0;
            end else if (r_db_cnt != DB_MAX) begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end
    end

    // Unmapped select codes never request a switch.
    assign w_stable = (r_db_cnt == DB_MAX);
    assign w_req    = w_stable && (r_cand != r_sel) && ({1'b0, r_cand} < NCH_LIM);

    always_comb begin
        w_next = RUN;
        if (r_state == RUN && w_req) w_next = SWITCH;
    end

    // The SWITCH cycle blanks the tick so no source can contribute twice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
            r_sel   <= SEL_RST;
            r_tick  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_tick  <= (r_state == RUN) ? (en & tick_i[r_sel]) : 1'b0;
            if (r_state == SWITCH) r_sel <= r_cand;
        end
    end

    assign tick_o      = r_tick;
    assign sel_o       = r_sel;
    assign switching_o = (r_state == SWITCH);
endmodule
